// File: rtl/mul_red_pipe_if.sv
// Operand/result bus of the lane-parallel dual-mode modular multiplier.
// The master drives operand beats; the slave (the multiplier) returns
// reduced products together with handshake and status flags.
interface mul_red_pipe_if #(
   parameter int LANES = 1
);
   logic                  in_valid;
   logic                  in_ready;
   logic [24*LANES-1:0]   A;
   logic [24*LANES-1:0]   w;
   logic                  mode;
   logic [1:0]            sel_a;
   logic                  out_valid;
   logic                  out_mode;
   logic [24*LANES-1:0]   result;
   logic                  busy;

   modport master (
      output in_valid, A, w, mode, sel_a,
      input  in_ready, out_valid, out_mode, result, busy
   );

   modport slave (
      input  in_valid, A, w, mode, sel_a,
      output in_ready, out_valid, out_mode, result, busy
   );
endinterface

// File: rtl/mul_red_pipe.sv
// Lane-parallel dual-mode modular multiplier.
// Each 24-bit lane yields either two Kyber products reduced mod KQ or one
// combined Dilithium product reduced mod DQ. A beat moves through four
// register stages (products, shifted sum, reductions, output), so its
// result shows up exactly four cycles after it is accepted. High operand
// halves can be taken from free-running delay lines to line up butterfly
// operands for the four-point NTT/INTT orderings.
module mul_red_pipe #(
   parameter int LANES     = 1,
   parameter int KQ        = 3329,
   parameter int DQ        = 8380417,
   parameter int DLY_LONG  = 7,
   parameter int DLY_SHORT = 1
) (
   input logic           clk,
   input logic           rst,
   mul_red_pipe_if.slave bus
);
   localparam int          LAT  = 4;
   localparam int          CW   = $clog2(LAT + 1);
   localparam logic [23:0] KQ_W = 24'(KQ);
   localparam logic [47:0] DQ_W = 48'(DQ);

   logic [11:0] a_long  [LANES][DLY_LONG];
   logic [11:0] w_long  [LANES][DLY_LONG];
   logic [11:0] a_short [LANES][DLY_SHORT];

   logic [11:0] op_ah [LANES];
   logic [11:0] op_wh [LANES];
   logic [11:0] op_al [LANES];
   logic [11:0] op_wl [LANES];

   logic [23:0] s1_p1 [LANES];
   logic [23:0] s1_p0 [LANES];
   logic [47:0] s2_s  [LANES];
   logic [23:0] s2_p1 [LANES];
   logic [23:0] s2_p0 [LANES];
   logic [23:0] red   [LANES];
   logic [23:0] s3_res[LANES];

   logic [LAT-1:0]      vld;
   logic [LAT-2:0]      tag;
   logic                out_mode_q;
   logic [24*LANES-1:0] out_res;
   logic [CW-1:0]       count;
   logic                conflict;
   logic                ready;
   logic                accept;

   assign accept = bus.in_valid && ready;

   // Alignment delay lines shift every cycle whatever the handshake does
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < DLY_LONG; j++) begin
               a_long[i][j] <= '0;
               w_long[i][j] <= '0;
            end
            for (int j = 0; j < DLY_SHORT; j++) begin
               a_short[i][j] <= '0;
            end
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            a_long[i][0]  <= bus.A[24*i+12 +: 12];
            w_long[i][0]  <= bus.w[24*i+12 +: 12];
            a_short[i][0] <= bus.A[24*i+12 +: 12];
            for (int j = 1; j < DLY_LONG; j++) begin
               a_long[i][j] <= a_long[i][j-1];
               w_long[i][j] <= w_long[i][j-1];
            end
            for (int j = 1; j < DLY_SHORT; j++) begin
               a_short[i][j] <= a_short[i][j-1];
            end
         end
      end
   end

   // Pick direct or delayed high halves according to the ordering in use
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         op_al[i] = bus.A[24*i +: 12];
         op_wl[i] = bus.w[24*i +: 12];
         op_ah[i] = bus.A[24*i+12 +: 12];
         op_wh[i] = bus.w[24*i+12 +: 12];
         if (bus.sel_a == 2'd1) begin
            op_ah[i] = a_long[i][DLY_LONG-1];
            op_wh[i] = w_long[i][DLY_LONG-1];
         end else if (bus.sel_a == 2'd2) begin
            op_ah[i] = a_short[i][DLY_SHORT-1];
         end
      end
   end

   // Reduce the stage-two values according to the mode tag of that beat
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         if (tag[1]) begin
            red[i] = {1'b0, 23'(s2_s[i] % DQ_W)};
         end else begin
            red[i] = {12'(s2_p1[i] % KQ_W), 12'(s2_p0[i] % KQ_W)};
         end
      end
   end

   // Datapath stages: products, shifted sum, reductions, held output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) begin
            s1_p1[i]  <= '0;
            s1_p0[i]  <= '0;
            s2_s[i]   <= '0;
            s2_p1[i]  <= '0;
            s2_p0[i]  <= '0;
            s3_res[i] <= '0;
         end
         out_res    <= '0;
         out_mode_q <= 1'b0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            s1_p1[i]  <= {12'b0, op_ah[i]} * {12'b0, op_wh[i]};
            s1_p0[i]  <= {12'b0, op_al[i]} * {12'b0, op_wl[i]};
            s2_s[i]   <= {s1_p1[i], 24'b0} + {12'b0, s1_p0[i], 12'b0};
            s2_p1[i]  <= s1_p1[i];
            s2_p0[i]  <= s1_p0[i];
            s3_res[i] <= red[i];
         end
         if (vld[LAT-2]) begin
            for (int i = 0; i < LANES; i++) begin
               out_res[24*i +: 24] <= s3_res[i];
            end
            out_mode_q <= tag[LAT-2];
         end
      end
   end

   // Valid bits and mode tags travel alongside the datapath stages
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         tag <= '0;
      end else begin
         vld <= {vld[LAT-2:0], accept};
         tag <= {tag[LAT-3:0], bus.mode};
      end
   end

   // In-flight beat count: up on accept, down when a result leaves
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({accept, vld[LAT-1]})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Hold off a beat whose mode differs from anything still in flight
   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < LAT-1; i++) begin
         if (vld[i] && (tag[i] != bus.mode)) begin
            conflict = 1'b1;
         end
      end
      if (vld[LAT-1] && (out_mode_q != bus.mode)) begin
         conflict = 1'b1;
      end
      ready = !(bus.in_valid && conflict);
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = vld[LAT-1];
   assign bus.out_mode  = out_mode_q;
   assign bus.result    = out_res;
   assign bus.busy      = (count != '0);
endmodule

// File: tb/tb_mul_red_pipe.sv
// Directed bench for the dual-mode modular multiplier: one single-lane and
// one four-lane instance, hand-computed expectations for Kyber and
// Dilithium arithmetic, latency, mode-switch drain, alignment delay
// selection and asynchronous reset.
module tb_mul_red_pipe;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   mul_red_pipe_if #(.LANES(1)) if1 ();
   mul_red_pipe_if #(.LANES(4)) if4 ();

   mul_red_pipe #(.LANES(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   mul_red_pipe #(.LANES(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (if4.slave)
   );

   // Free-running clock with a 10-unit period
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
      end
   endtask

   task automatic checkWord(input string name, input logic [23:0] observed, input logic [23:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%06h expected=%06h", name, observed, expected);
      end
   endtask

   task automatic checkWide(input string name, input logic [95:0] observed, input logic [95:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%024h expected=%024h", name, observed, expected);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic m, input logic [1:0] s,
                                input logic [23:0] a, input logic [23:0] b);
      if1.in_valid = v;
      if1.mode     = m;
      if1.sel_a    = s;
      if1.A        = a;
      if1.w        = b;
   endtask

   task automatic applyStimulus4(input logic v, input logic m,
                                 input logic [95:0] a, input logic [95:0] b);
      if4.in_valid = v;
      if4.mode     = m;
      if4.sel_a    = 2'd0;
      if4.A        = a;
      if4.w        = b;
   endtask

   // One isolated beat on the single-lane instance, checked over its life
   task automatic runBeat(input string name, input logic m, input logic [1:0] s,
                          input logic [23:0] a, input logic [23:0] b, input logic [23:0] expected);
      applyStimulus(1'b1, m, s, a, b);
      #1;
      checkOutput({name, "_ready"}, if1.in_ready, 1'b1);
      tick;
      if1.in_valid = 1'b0;
      checkOutput({name, "_busy"}, if1.busy, 1'b1);
      tick;
      tick;
      checkOutput({name, "_early"}, if1.out_valid, 1'b0);
      tick;
      checkOutput({name, "_valid"}, if1.out_valid, 1'b1);
      checkWord({name, "_result"}, if1.result, expected);
      checkOutput({name, "_mode"}, if1.out_mode, m);
      tick;
      checkOutput({name, "_done"}, if1.out_valid, 1'b0);
      checkWord({name, "_hold"}, if1.result, expected);
      checkOutput({name, "_idle"}, if1.busy, 1'b0);
   endtask

   // One isolated beat on the four-lane instance
   task automatic runBeat4(input string name, input logic m,
                           input logic [95:0] a, input logic [95:0] b, input logic [95:0] expected);
      applyStimulus4(1'b1, m, a, b);
      tick;
      if4.in_valid = 1'b0;
      tick;
      tick;
      tick;
      checkOutput({name, "_valid"}, if4.out_valid, 1'b1);
      checkWide({name, "_result"}, if4.result, expected);
      checkOutput({name, "_mode"}, if4.out_mode, m);
      tick;
   endtask

   // Feed A_high=k, w_high=1 for k=1..10 and issue the beat on k=10
   task automatic alignRun(input string name, input logic [1:0] s, input logic [23:0] expected);
      logic [11:0] kk;
      for (int k = 1; k <= 10; k++) begin
         kk = 12'(k);
         applyStimulus(k == 10, 1'b0, s, {kk, 12'h001}, 24'h001001);
         tick;
      end
      if1.in_valid = 1'b0;
      tick;
      tick;
      tick;
      checkOutput({name, "_valid"}, if1.out_valid, 1'b1);
      checkWord({name, "_result"}, if1.result, expected);
      tick;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 2'd0, 24'h005003, 24'h007004);
      applyStimulus4(1'b0, 1'b0, 96'h0, 96'h0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_ready", if1.in_ready, 1'b1);
      checkOutput("rst_out_valid", if1.out_valid, 1'b0);
      checkOutput("rst_out_mode", if1.out_mode, 1'b0);
      checkWord("rst_result", if1.result, 24'h000000);
      checkOutput("rst_busy", if1.busy, 1'b0);
      checkWide("rst_result4", if4.result, 96'h0);
      rst = 1'b0;

      // Delayed taps are still empty right after reset: high product is 0
      runBeat("empty_taps", 1'b0, 2'd1, 24'h005003, 24'h007004, 24'h00000C);

      runBeat("kyb_basic", 1'b0, 2'd0, 24'h002003, 24'h681456, 24'h001001);
      runBeat("kyb_lowmax", 1'b0, 2'd0, 24'h000FFF, 24'h000FFF, 24'h000354);
      runBeat("kyb_bothmax", 1'b0, 2'd0, 24'hFFFFFF, 24'hFFFFFF, 24'h354354);
      runBeat("dil_2p24", 1'b1, 2'd0, 24'h001000, 24'h001000, 24'h003FFE);
      runBeat("dil_one", 1'b1, 2'd0, 24'h000001, 24'h000001, 24'h001000);
      runBeat("dil_max", 1'b1, 2'd0, 24'hFFFFFF, 24'hFFFFFF, 24'h01EFEE);
      runBeat("kyb_after_dil", 1'b0, 2'd0, 24'h005007, 24'h003002, 24'h00F00E);

      // Three Kyber beats back to back, then a Dilithium beat must drain
      applyStimulus(1'b1, 1'b0, 2'd0, 24'h002003, 24'h681456);
      #1;
      checkOutput("sw_c0_ready", if1.in_ready, 1'b1);
      tick;
      applyStimulus(1'b1, 1'b0, 2'd0, 24'h000FFF, 24'h000FFF);
      tick;
      applyStimulus(1'b1, 1'b0, 2'd0, 24'h005007, 24'h003002);
      tick;
      applyStimulus(1'b1, 1'b1, 2'd0, 24'h001000, 24'h001000);
      #1;
      checkOutput("sw_c3_ready", if1.in_ready, 1'b0);
      checkOutput("sw_c3_busy", if1.busy, 1'b1);
      tick;
      checkOutput("sw_c4_ready", if1.in_ready, 1'b0);
      checkOutput("sw_c4_valid", if1.out_valid, 1'b1);
      checkWord("sw_c4_result", if1.result, 24'h001001);
      checkOutput("sw_c4_mode", if1.out_mode, 1'b0);
      tick;
      checkOutput("sw_c5_ready", if1.in_ready, 1'b0);
      checkWord("sw_c5_result", if1.result, 24'h000354);
      tick;
      checkOutput("sw_c6_ready", if1.in_ready, 1'b0);
      checkWord("sw_c6_result", if1.result, 24'h00F00E);
      checkOutput("sw_c6_mode", if1.out_mode, 1'b0);
      tick;
      checkOutput("sw_c7_ready", if1.in_ready, 1'b1);
      checkOutput("sw_c7_valid", if1.out_valid, 1'b0);
      checkOutput("sw_c7_busy", if1.busy, 1'b0);
      tick;
      if1.in_valid = 1'b0;
      tick;
      tick;
      checkOutput("sw_c10_valid", if1.out_valid, 1'b0);
      checkWord("sw_c10_hold", if1.result, 24'h00F00E);
      checkOutput("sw_c10_mode", if1.out_mode, 1'b0);
      tick;
      checkOutput("sw_c11_valid", if1.out_valid, 1'b1);
      checkWord("sw_c11_result", if1.result, 24'h003FFE);
      checkOutput("sw_c11_mode", if1.out_mode, 1'b1);
      tick;
      checkOutput("sw_c12_valid", if1.out_valid, 1'b0);
      checkOutput("sw_c12_mode", if1.out_mode, 1'b1);
      checkOutput("sw_c12_busy", if1.busy, 1'b0);

      // Operand alignment: long delay, short delay, and direct
      alignRun("align_long", 2'd1, 24'h003001);
      alignRun("align_short", 2'd2, 24'h009001);
      alignRun("align_direct", 2'd3, 24'h00A001);

      // Four independent lanes in each mode
      runBeat4("lanes_kyb", 1'b0,
               {24'h00A000, 24'h005007, 24'h000FFF, 24'h002003},
               {24'h00B000, 24'h003002, 24'h000FFF, 24'h681456},
               {24'h06E000, 24'h00F00E, 24'h000354, 24'h001001});
      runBeat4("lanes_dil", 1'b1,
               {24'h002000, 24'h000000, 24'h000001, 24'h001000},
               {24'h002000, 24'h000000, 24'h000001, 24'h001000},
               {24'h00FFF8, 24'h000000, 24'h001000, 24'h003FFE});

      // Asynchronous reset with three beats in flight
      applyStimulus(1'b1, 1'b0, 2'd0, 24'h002003, 24'h681456);
      tick;
      applyStimulus(1'b1, 1'b0, 2'd0, 24'h000FFF, 24'h000FFF);
      tick;
      applyStimulus(1'b1, 1'b0, 2'd0, 24'h005007, 24'h003002);
      tick;
      if1.in_valid = 1'b0;
      tick;
      checkOutput("mid_valid", if1.out_valid, 1'b1);
      checkWord("mid_result", if1.result, 24'h001001);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_valid", if1.out_valid, 1'b0);
      checkWord("arst_result", if1.result, 24'h000000);
      checkOutput("arst_busy", if1.busy, 1'b0);
      checkOutput("arst_ready", if1.in_ready, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick;
         checkOutput("post_rst_valid", if1.out_valid, 1'b0);
         checkOutput("post_rst_busy", if1.busy, 1'b0);
      end
      runBeat("post_rst_beat", 1'b0, 2'd0, 24'h002003, 24'h681456, 24'h001001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
